// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS checker with saturating bit/error counters.
// Optional loss-of-lock detection is built when PRBS_CHECKER_RELOCK_EN is defined.
module prbs_checker #(
    parameter int N          = 7,
    parameter int TAP_A      = 7,
    parameter int TAP_B      = 6,
    parameter int LOCK_COUNT = 32,
    parameter int ERR_WIDTH  = 32,
    parameter int BIT_WIDTH  = 48
`ifdef PRBS_CHECKER_RELOCK_EN
    ,
    parameter int RELOCK_WIN  = 64,
    parameter int RELOCK_ERRS = 8
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_bit,
    input  logic                 clear,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic [BIT_WIDTH-1:0] bit_count
);
    localparam int FW = $clog2(N + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

    state_t         state, state_nx;
    logic [N-1:0]   hist, hist_nx;
    logic [FW-1:0]  fill, fill_nx;
    logic [MW-1:0]  match, match_nx;
    logic           pred, miss, count_bit, count_err, win_drop;

    assign pred      = hist[TAP_A-1] ^ hist[TAP_B-1];
    assign miss      = in_bit != pred;
    assign count_bit = in_valid && state == LOCKED;
    assign count_err = count_bit && miss;
    assign locked    = state == LOCKED;

`ifdef PRBS_CHECKER_RELOCK_EN
    localparam int WW = $clog2(RELOCK_WIN + 1);
    localparam int EW = $clog2(RELOCK_ERRS + 1);

    logic [WW-1:0] win_cnt;
    logic [EW-1:0] win_err;

    assign win_drop = miss && win_err == EW'(RELOCK_ERRS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
            win_err <= '0;
        end else if (state_nx != LOCKED || (count_bit && win_cnt == WW'(RELOCK_WIN - 1))) begin
            win_cnt <= '0;
            win_err <= '0;
        end else if (count_bit) begin
            win_cnt <= win_cnt + 1'b1;
            win_err <= win_err + EW'(miss);
        end
    end
`else
    assign win_drop = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        hist_nx  = hist;
        fill_nx  = fill;
        match_nx = match;
        if (in_valid) begin
            case (state)
                SEED: begin
                    hist_nx = {hist[N-2:0], in_bit};
                    fill_nx = fill + 1'b1;
                    if (fill == FW'(N - 1)) begin
                        state_nx = VERIFY;
                        match_nx = '0;
                    end
                end
                VERIFY: begin
                    hist_nx = {hist[N-2:0], in_bit};
                    if (miss) begin
                        state_nx = SEED;
                        fill_nx  = '0;
                    end else begin
                        match_nx = match + 1'b1;
                        if (match == MW'(LOCK_COUNT - 1)) state_nx = LOCKED;
                    end
                end
                LOCKED: begin
                    // Feed the predictor from itself so a bad sample cannot corrupt later predictions
                    hist_nx = {hist[N-2:0], pred};
                    if (win_drop) begin
                        state_nx = SEED;
                        fill_nx  = '0;
                    end
                end
                default: state_nx = SEED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEED;
            hist      <= '0;
            fill      <= '0;
            match     <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            state     <= state_nx;
            hist      <= hist_nx;
            fill      <= fill_nx;
            match     <= match_nx;
            err_pulse <= count_err;
            err_count <= clear ? '0 : (count_err && !(&err_count)) ? err_count + 1'b1 : err_count;
            bit_count <= clear ? '0 : (count_bit && !(&bit_count)) ? bit_count + 1'b1 : bit_count;
        end
    end
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: randomized PRBS7 stimulus against a lock/count model derived from the checker rules.
// A second instance with narrow counters exercises saturation.
module tb_prbs_checker;
    logic        clk = 0, rst_n = 0, in_valid = 0, in_bit = 0, clear = 0;
    logic        locked, err_pulse, s_locked, s_pulse;
    logic [31:0] err_count;
    logic [47:0] bit_count;
    logic [3:0]  s_err;
    logic [7:0]  s_bits;

    int          errors = 0, checks = 0;
    logic [6:0]  gen = 7'h5a;
    logic        inv = 0, force_one = 0;
    int          sync_cnt = 0;
    longint      exp_bits = 0, exp_errs = 0;
    logic        exp_pulse = 0;

    always #5 clk = ~clk;

    prbs_checker u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count)
    );

    prbs_checker #(.ERR_WIDTH(4), .BIT_WIDTH(8)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
        .locked(s_locked), .err_pulse(s_pulse), .err_count(s_err), .bit_count(s_bits)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One sample through the checker; the model counts valid bits since the last resync.
    // The checker is locked once 7 fill + 32 matching bits have been seen.
    task automatic send(input logic v, input logic flip, input logic clr);
        logic b, nb, was_locked;
        if (v) begin
            nb  = gen[6] ^ gen[5];
            gen = {gen[5:0], nb};
            b   = force_one ? 1'b1 : nb ^ flip ^ inv;
        end else begin
            b = 1'($urandom_range(0, 1));
        end
        was_locked = v && sync_cnt >= 39;
        in_valid = v;
        in_bit   = b;
        clear    = clr;
        @(posedge clk);
        #1;
        if (v) sync_cnt++;
        exp_pulse = was_locked && (flip ^ inv);
        if (clr) begin
            exp_bits = 0;
            exp_errs = 0;
        end else if (was_locked) begin
            exp_bits++;
            if (flip ^ inv) exp_errs++;
        end
        in_valid = 0;
        clear    = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #2;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b want 0", locked); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %0b want 0", err_pulse); end
        checks++; if (err_count !== 32'd0) begin errors++; $display("FAIL reset_err got %0d want 0", err_count); end
        checks++; if (bit_count !== 48'd0) begin errors++; $display("FAIL reset_bits got %0d want 0", bit_count); end
        checks++; if (s_err !== 4'd0 || s_bits !== 8'd0) begin errors++; $display("FAIL reset_sat got %0d/%0d want 0/0", s_err, s_bits); end
        @(posedge clk);
        #1;
        rst_n = 1;
        gen = 7'($urandom_range(1, 127));
        inv = 0;
        sync_cnt = 0;
        exp_bits = 0;
        exp_errs = 0;
    endtask

    task automatic test_clean_lock();
        int np = 0;
        test_reset();
        repeat (38) send(1, 0, 0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early got %0b want 0", locked); end
        send(1, 0, 0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_at_39 got %0b want 1", locked); end
        repeat (1000) begin
            send(1, 0, 0);
            np += int'(err_pulse);
        end
        checks++; if (bit_count !== 48'd1000) begin errors++; $display("FAIL clean_bits got %0d want 1000", bit_count); end
        checks++; if (err_count !== 32'd0) begin errors++; $display("FAIL clean_errs got %0d want 0", err_count); end
        checks++; if (np != 0) begin errors++; $display("FAIL clean_pulses got %0d want 0", np); end
    endtask

    task automatic test_errors();
        int np = 0;
        int r = $urandom_range(0, 9);
        longint base = exp_bits;
        for (int i = 0; i < 60; i++) begin
            send(1, i >= r && (i - r) % 20 == 0, 0);
            np += int'(err_pulse);
            checks++; if (err_pulse !== exp_pulse) begin errors++; $display("FAIL pulse_%0d got %0b want %0b", i, err_pulse, exp_pulse); end
        end
        checks++; if (err_count !== 32'd3) begin errors++; $display("FAIL iso_errs got %0d want 3", err_count); end
        checks++; if (np != 3) begin errors++; $display("FAIL iso_pulses got %0d want 3", np); end
        checks++; if (bit_count !== 48'(base + 60)) begin errors++; $display("FAIL iso_bits got %0d want %0d", bit_count, base + 60); end
    endtask

    task automatic test_verify_error();
        test_reset();
        repeat (26) send(1, 0, 0);
        send(1, 1, 0);
        sync_cnt = 0;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL verr_locked got %0b want 0", locked); end
        repeat (38) send(1, 0, 0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL verr_early got %0b want 0", locked); end
        send(1, 0, 0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL verr_relock got %0b want 1", locked); end
        checks++; if (err_count !== 32'd0) begin errors++; $display("FAIL verr_errs got %0d want 0", err_count); end
    endtask

    task automatic test_gaps();
        test_reset();
        for (int i = 0; i < 300; i++) begin
            send(1'($urandom_range(0, 1)), 0, 0);
            checks++; if (locked !== (sync_cnt >= 39)) begin errors++; $display("FAIL gap_lock_%0d got %0b want %0b", i, locked, sync_cnt >= 39); end
            checks++; if (bit_count !== 48'(exp_bits)) begin errors++; $display("FAIL gap_bits_%0d got %0d want %0d", i, bit_count, exp_bits); end
            checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL gap_pulse_%0d got %0b want 0", i, err_pulse); end
        end
    endtask

    task automatic test_const_one();
        int seen = 0;
        test_reset();
        force_one = 1;
        repeat (100) begin
            send(1, 0, 0);
            seen += int'(locked);
        end
        force_one = 0;
        checks++; if (seen != 0) begin errors++; $display("FAIL ones_locked got %0d want 0", seen); end
    endtask

    task automatic test_saturation();
        test_reset();
        repeat (39) send(1, 0, 0);
        for (int i = 0; i < 200; i++) send(1, i % 10 == 0, 0);
        checks++; if (err_count !== 32'(exp_errs) || exp_errs != 20) begin errors++; $display("FAIL sat_errs got %0d want 20", err_count); end
        checks++; if (s_err !== 4'd15) begin errors++; $display("FAIL sat_small_errs got %0d want 15", s_err); end
        repeat (100) send(1, 0, 0);
        checks++; if (bit_count !== 48'd300) begin errors++; $display("FAIL sat_bits got %0d want 300", bit_count); end
        checks++; if (s_bits !== 8'd255) begin errors++; $display("FAIL sat_small_bits got %0d want 255", s_bits); end
        send(1, 1, 1);
        checks++; if (err_count !== 32'd0 || s_err !== 4'd0) begin errors++; $display("FAIL clr_errs got %0d/%0d want 0/0", err_count, s_err); end
        checks++; if (bit_count !== 48'd0 || s_bits !== 8'd0) begin errors++; $display("FAIL clr_bits got %0d/%0d want 0/0", bit_count, s_bits); end
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL clr_pulse got %0b want 1", err_pulse); end
        send(1, 0, 0);
        checks++; if (bit_count !== 48'd1) begin errors++; $display("FAIL clr_resume got %0d want 1", bit_count); end
    endtask

    task automatic test_invert();
        test_reset();
        repeat (39) send(1, 0, 0);
        inv = 1;
`ifdef PRBS_CHECKER_RELOCK_EN
        repeat (7) send(1, 0, 0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL inv_hold got %0b want 1", locked); end
        send(1, 0, 0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL inv_drop got %0b want 0", locked); end
        checks++; if (err_count !== 32'd8) begin errors++; $display("FAIL inv_errs got %0d want 8", err_count); end
        inv = 0;
        sync_cnt = 0;
        repeat (39) send(1, 0, 0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL inv_relock got %0b want 1", locked); end
        checks++; if (err_count !== 32'd8) begin errors++; $display("FAIL inv_keep got %0d want 8", err_count); end
`else
        repeat (40) send(1, 0, 0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL inv_locked got %0b want 1", locked); end
        checks++; if (err_count !== 32'd40) begin errors++; $display("FAIL inv_errs got %0d want 40", err_count); end
        checks++; if (s_err !== 4'd15) begin errors++; $display("FAIL inv_small got %0d want 15", s_err); end
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL inv_pulse got %0b want 1", err_pulse); end
`endif
        inv = 0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_clean_lock();
        test_errors();
        test_verify_error();
        test_gaps();
        test_const_one();
        test_saturation();
        test_invert();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
